// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling frame FSM and a
// first-word-fall-through FIFO of {ferr, perr, data} with sticky overrun.
module uart_rx_fifo #(
   parameter int unsigned CLK_PER_HALF_BIT = 5208,
   parameter int unsigned DATA_BITS        = 8,
   parameter int unsigned PARITY           = 0,
   parameter int unsigned STOP_BITS        = 1,
   parameter int unsigned FIFO_DEPTH       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rdata,
   output logic                 rdata_ferr,
   output logic                 rdata_perr,
   output logic                 rdata_valid,
   input  logic                 rdata_ready,
   output logic                 overrun,
   input  logic                 err_clr
);

   localparam int unsigned CNT_W   = $clog2(2 * CLK_PER_HALF_BIT);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned ENT_W   = DATA_BITS + 2;
   localparam int unsigned BIDX_W  = 4;
   localparam int unsigned CNT_MID = CLK_PER_HALF_BIT - 1;
   localparam int unsigned CNT_END = 2 * CLK_PER_HALF_BIT - 1;
   localparam logic        PAR_ODD = 1'(PARITY == 32'd1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [BIDX_W-1:0]    bidx, bidx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic                 ferr_f, ferr_n;
   logic                 perr_f, perr_n;
   logic                 push_q, push_n;
   logic                 sync1, rxs;
   logic                 at_mid, at_end;

   // Frame FSM: next state, counters and frame assembly
   always_comb begin
      state_n = state;
      bidx_n  = bidx;
      sh_n    = sh;
      ferr_n  = ferr_f;
      perr_n  = perr_f;
      push_n  = 1'b0;
      at_mid  = (cnt == CNT_W'(CNT_MID));
      at_end  = (cnt == CNT_W'(CNT_END));

      case (state)
         S_IDLE: begin
            if (!rxs) state_n = S_START;
         end
         S_START: begin
            bidx_n = '0;
            ferr_n = 1'b0;
            perr_n = 1'b0;
            if (at_mid) state_n = rxs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (at_end) begin
               sh_n = {rxs, sh[DATA_BITS-1:1]};
               if (bidx == BIDX_W'(DATA_BITS - 1)) begin
                  bidx_n  = '0;
                  state_n = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bidx_n = bidx + BIDX_W'(1);
               end
            end
         end
         S_PAR: begin
            if (at_end) begin
               perr_n  = ((^sh) ^ rxs) != PAR_ODD;
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (at_end) begin
               if (!rxs) ferr_n = 1'b1;
               if (bidx == BIDX_W'(STOP_BITS - 1)) begin
                  push_n  = 1'b1;
                  bidx_n  = '0;
                  state_n = rxs ? S_IDLE : S_WAIT_HIGH;
               end else begin
                  bidx_n = bidx + BIDX_W'(1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (rxs) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // Counter restarts on any state change and wraps once per bit
      if (state_n != state || state == S_IDLE || at_end) cnt_n = '0;
      else                                               cnt_n = cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b1;
         rxs    <= 1'b1;
         state  <= S_IDLE;
         cnt    <= '0;
         bidx   <= '0;
         sh     <= '0;
         ferr_f <= 1'b0;
         perr_f <= 1'b0;
         push_q <= 1'b0;
      end else begin
         sync1  <= rxd;
         rxs    <= sync1;
         state  <= state_n;
         cnt    <= cnt_n;
         bidx   <= bidx_n;
         sh     <= sh_n;
         ferr_f <= ferr_n;
         perr_f <= perr_n;
         push_q <= push_n;
      end
   end

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
   logic [PTR_W:0]   count, count_ap;
   logic             pop, full, do_push, drop;

   // Head after this cycle's pop (count_ap excludes a same-cycle push)
   always_comb begin
      pop      = rdata_valid & rdata_ready;
      full     = (count == (PTR_W+1)'(FIFO_DEPTH));
      do_push  = push_q & (~full | pop);
      drop     = push_q & full & ~pop;
      count_ap = count - (PTR_W+1)'(pop);
      rd_ptr_n = rd_ptr + PTR_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {ferr_f, perr_f, sh};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rdata       <= '0;
         rdata_ferr  <= 1'b0;
         rdata_perr  <= 1'b0;
         rdata_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr      <= rd_ptr_n;
         count       <= count_ap + (PTR_W+1)'(do_push);
         rdata_valid <= (count_ap != '0);
         if (count_ap != '0) {rdata_ferr, rdata_perr, rdata} <= mem[rd_ptr_n];
         else                {rdata_ferr, rdata_perr, rdata} <= '0;
         // Set beats clear when both happen together
         if (drop)         overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receive front end: samples an asynchronous serial line at mid-bit, assembles frames of configurable data width, parity mode and stop-bit count, and queues received words with per-word error flags in a small FIFO. A valid/ready interface lets the consumer (core I/O unit or loader) pop words at its own pace, so back-to-back frames are not lost while the consumer is stalled. Sticky overrun reporting covers words dropped while the FIFO is full.

## Interface
- `CLK_PER_HALF_BIT`, 5208: clocks per half bit period; legal ≥ 2; one bit = 2*CLK_PER_HALF_BIT clocks.
- `DATA_BITS`, 8: data bits per frame, legal 5..8, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries, power of two ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rxd`  in  1  asynchronous serial input, idle high.
- `rdata`  out  DATA_BITS  data of FIFO head entry.
- `rdata_ferr`  out  1  head entry had a framing error.
- `rdata_perr`  out  1  head entry had a parity error (always 0 when PARITY = 0).
- `rdata_valid`  out  1  FIFO non-empty; head is presented.
- `rdata_ready`  in  1  consumer pop; pop occurs when valid & ready.
- `overrun`  out  1  sticky: a completed frame was dropped because the FIFO was full.
- `err_clr`  in  1  one-cycle pulse clears `overrun`.

## Operation
- `rxd` passes through a 2-flop synchroniser (both flops reset to 1); all references below to the line mean the synchronised value `rxs`.
- Bit counter: counts 0..2*CLK_PER_HALF_BIT-1 and wraps; cleared on every state change noted "restart".
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE: `rxs` = 0 -> START, restart.
- START: at counter = CLK_PER_HALF_BIT-1 (mid start bit) sample; `rxs` = 1 -> IDLE (glitch, nothing queued); `rxs` = 0 -> DATA, restart.
- DATA: at counter = 2*CLK_PER_HALF_BIT-1 shift `rxs` into shift register MSB side (LSB-first assembly); after DATA_BITS samples -> PAR if PARITY ≠ 0 else STOP.
- PAR: one sample at same point; perr = (XOR of data bits ^ parity bit) ≠ (PARITY = 1 ? 1 : 0).
- STOP: STOP_BITS samples at same point; any stop sample = 0 sets ferr for the frame. After last stop sample: push {data, ferr, perr}; next state IDLE if last sample = 1, WAIT_HIGH if 0.
- WAIT_HIGH: stay until `rxs` = 1, then IDLE (prevents a break/low line from being read as a new start bit).
- FIFO: first-word-fall-through; `rdata*` show head whenever `rdata_valid` = 1; values undefined-but-stable when empty are driven 0.
- Push while full with no simultaneous pop: frame dropped, `overrun` <= 1. Push and pop in same cycle while full: both succeed, no overrun. Push and pop while empty: push only (pop ignored, valid was 0).
- `overrun` set and `err_clr` in same cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit or count register.

## Timing
- Reset: FSM IDLE, counter 0, FIFO empty, `rdata` = 0, `rdata_ferr` = 0, `rdata_perr` = 0, `rdata_valid` = 0, `overrun` = 0, synchroniser = 1. Reset mid-frame abandons the frame; nothing is pushed.
- `rxd` fall to `rxs` fall: 2 cycles; START entered 1 cycle later.
- Push occurs on the clock edge after the last stop sample; `rdata_valid` rises on the following edge (FIFO was empty).
- Pop: head advances on the edge where valid & ready; next entry visible that cycle +1; `rdata_valid` falls the same edge if last entry.
- Last stop sample is at mid stop bit, so IDLE is re-entered with half a bit of margin: back-to-back frames with no idle gap are received.

## Test plan
- CLK_PER_HALF_BIT=4, 8N1, send 0xA5 -> one entry rdata=0xA5, ferr=0, perr=0, valid rises 2 cycles after last stop sample.
- PARITY=2, send 0x03 with parity bit 1 -> rdata=0x03, perr=1; repeat with parity bit 0 -> perr=0.
- 8N1, 0x55 with stop bit 0 and line held low 30 cycles -> entry 0x55 ferr=1; no second entry; next frame after line high received correctly.
- `rxd` low for 3 cycles (< half bit) -> no entry, FSM back to IDLE.
- FIFO_DEPTH=2, ready=0, three back-to-back frames 0x11, 0x22, 0x33 -> entries 0x11, 0x22, overrun=1; err_clr -> overrun=0; pops return 0x11 then 0x22 then valid=0.
- STOP_BITS=2, DATA_BITS=7, ready=1, 4 back-to-back frames, plus rst asserted mid-frame -> all complete frames received in order, interrupted frame discarded, all outputs 0 after reset.
